// File: rtl/smooth_pkg.sv
//==============================================================================
// Module  : smooth_pkg
// Brief   : Shared state encoding and sizing constants for the smoothing
//           column scheduler.
// Rev     : 1.0  initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

package smooth_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        PRE   = 3'd2,
        RUN   = 3'd3,
        POST  = 3'd4,
        DRAIN = 3'd5
    } sched_state_e;

    localparam int KSIZE = 5;   // kernel rows/columns
    localparam int PAD   = 2;   // pad columns on each side of a line
    localparam int PIX_W = 8;
    localparam int CNT_W = 12;

endpackage

`default_nettype wire

// File: rtl/smooth_line_buffer.sv
//==============================================================================
// Module  : smooth_line_buffer
// Brief   : DEPTH-entry line memory, synchronous write with asynchronous read,
//           so a same-address read in the write cycle returns the old word.
// Rev     : 1.0  initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module smooth_line_buffer #(
    parameter int DEPTH  = 640,
    parameter int DATA_W = 32,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

`default_nettype wire

// File: rtl/smooth_col_sched.sv
//==============================================================================
// Module  : smooth_col_sched
// Brief   : Raster-scan column sequencer for the 5x5 smoother: buffers four
//           lines, emits 5-pixel columns and inserts pad columns/drain rows.
//           Optional macro SMOOTH_REPLICATE_EN selects border replication
//           instead of zero padding.
// Rev     : 1.0  initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module smooth_col_sched
    import smooth_pkg::*;
#(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_start,
    input  logic [PIX_W-1:0]         i_pixel,
    input  logic                     i_valid,
    output logic                     o_ready,
    output logic [KSIZE*PIX_W-1:0]   o_col,
    output logic                     o_col_valid,
    output logic                     o_center_real,
    output logic                     o_busy,
    output logic                     o_frame_done
);

    localparam int                c_ADDR_W = $clog2(WIDTH);
    localparam int                c_COL_W  = KSIZE * PIX_W;
    localparam int                c_LB_W   = (KSIZE - 1) * PIX_W;
    localparam logic [CNT_W-1:0]  c_X_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]  c_Y_LAST = CNT_W'(HEIGHT - 1);
    localparam logic [CNT_W-1:0]  c_X_REAL = CNT_W'(PAD);

    sched_state_e         r_state;
    logic [CNT_W-1:0]     r_x;
    logic [CNT_W-1:0]     r_y;
    logic                 r_pad;
    logic                 r_drain;
    logic                 r_draining;
    logic [c_COL_W-1:0]   r_col;
    logic                 r_col_valid;
    logic                 r_center_real;
    logic                 r_frame_done;

    logic [c_ADDR_W-1:0]  w_lb_addr;
    logic                 w_lb_we;
    logic [c_LB_W-1:0]    w_lb_wdata;
    logic [c_LB_W-1:0]    w_lb_rdata;
    logic [PIX_W-1:0]     w_fill;
    logic [c_LB_W-1:0]    w_row0_word;
    logic [c_COL_W-1:0]   w_run_col;
    logic [c_COL_W-1:0]   w_drain_col;
    logic [c_COL_W-1:0]   w_pre_col;
    logic [c_COL_W-1:0]   w_post_col;

    // One 32-bit word per x holds rows y-4..y-1, oldest row in the top byte.
    smooth_line_buffer #(
        .DEPTH  (WIDTH),
        .DATA_W (c_LB_W)
    ) u_lb (
        .i_clk   (i_clk),
        .i_we    (w_lb_we),
        .i_addr  (w_lb_addr),
        .i_wdata (w_lb_wdata),
        .o_rdata (w_lb_rdata)
    );

    assign w_lb_addr   = r_x[c_ADDR_W-1:0];
    assign w_run_col   = {w_lb_rdata, i_pixel};
    assign w_drain_col = {w_lb_rdata, w_fill};

`ifdef SMOOTH_REPLICATE_EN
    logic [c_COL_W-1:0]   r_held;

    // Missing rows repeat the newest buffered row; rows above row 0 repeat row 0.
    assign w_fill      = w_lb_rdata[PIX_W-1:0];
    assign w_row0_word = {(KSIZE - 1){i_pixel}};
    // The left pad precedes the row's first pixel, so its bottom entry
    // reuses the nearest buffered row at x=0.
    assign w_pre_col   = {w_lb_rdata, w_lb_rdata[PIX_W-1:0]};
    assign w_post_col  = r_held;
`else
    assign w_fill      = '0;
    assign w_row0_word = {{(c_LB_W - PIX_W){1'b0}}, i_pixel};
    assign w_pre_col   = '0;
    assign w_post_col  = '0;
`endif

    always_comb begin
        w_lb_we    = 1'b0;
        w_lb_wdata = {w_lb_rdata[c_LB_W-PIX_W-1:0], i_pixel};
        case (r_state)
            FILL: begin
                w_lb_we = i_valid;
                if (r_y == '0) begin
                    w_lb_wdata = w_row0_word;
                end
            end
            RUN: begin
                w_lb_we = i_valid;
            end
            DRAIN: begin
                w_lb_we    = 1'b1;
                w_lb_wdata = {w_lb_rdata[c_LB_W-PIX_W-1:0], w_fill};
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= IDLE;
            r_x           <= '0;
            r_y           <= '0;
            r_pad         <= 1'b0;
            r_drain       <= 1'b0;
            r_draining    <= 1'b0;
            r_col         <= '0;
            r_col_valid   <= 1'b0;
            r_center_real <= 1'b0;
            r_frame_done  <= 1'b0;
`ifdef SMOOTH_REPLICATE_EN
            r_held        <= '0;
`endif
        end else begin
            r_col_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_state    <= FILL;
                        r_x        <= '0;
                        r_y        <= '0;
                        r_pad      <= 1'b0;
                        r_drain    <= 1'b0;
                        r_draining <= 1'b0;
                    end
                end
                FILL: begin
                    if (i_valid) begin
                        if (r_x == c_X_LAST) begin
                            r_x <= '0;
                            r_y <= r_y + 1'b1;
                            if (r_y == CNT_W'(1)) begin
                                r_state <= PRE;
                            end
                        end else begin
                            r_x <= r_x + 1'b1;
                        end
                    end
                end
                PRE: begin
                    r_col         <= w_pre_col;
                    r_col_valid   <= 1'b1;
                    r_center_real <= 1'b0;
                    r_pad         <= ~r_pad;
                    if (r_pad) begin
                        r_state <= r_draining ? DRAIN : RUN;
                    end
                end
                RUN: begin
                    if (i_valid) begin
                        r_col         <= w_run_col;
                        r_col_valid   <= 1'b1;
                        r_center_real <= (r_x >= c_X_REAL);
                        if (r_x == c_X_LAST) begin
                            r_x     <= '0;
                            r_state <= POST;
`ifdef SMOOTH_REPLICATE_EN
                            r_held  <= w_run_col;
`endif
                        end else begin
                            r_x <= r_x + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    r_col         <= w_drain_col;
                    r_col_valid   <= 1'b1;
                    r_center_real <= (r_x >= c_X_REAL);
                    if (r_x == c_X_LAST) begin
                        r_x     <= '0;
                        r_state <= POST;
`ifdef SMOOTH_REPLICATE_EN
                        r_held  <= w_drain_col;
`endif
                    end else begin
                        r_x <= r_x + 1'b1;
                    end
                end
                POST: begin
                    r_col         <= w_post_col;
                    r_col_valid   <= 1'b1;
                    r_center_real <= 1'b1;
                    r_pad         <= ~r_pad;
                    if (r_pad) begin
                        r_state <= PRE;
                        if (r_draining) begin
                            if (r_drain) begin
                                r_frame_done <= 1'b1;
                                r_state      <= IDLE;
                            end else begin
                                r_drain <= 1'b1;
                            end
                        end else if (r_y == c_Y_LAST) begin
                            r_draining <= 1'b1;
                        end else begin
                            r_y <= r_y + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_ready       = (r_state == FILL) || (r_state == RUN);
    assign o_busy        = (r_state != IDLE);
    assign o_col         = r_col;
    assign o_col_valid   = r_col_valid;
    assign o_center_real = r_center_real;
    assign o_frame_done  = r_frame_done;

endmodule

`default_nettype wire

// File: tb/tb_smooth_col_sched.sv
//==============================================================================
// Module  : tb_smooth_col_sched
// Brief   : Self-checking bench for smooth_col_sched (WIDTH=8, HEIGHT=6).
// Rev     : 1.0  initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_smooth_col_sched;

    localparam int W    = 8;
    localparam int H    = 6;
    localparam int COLS = H * (W + 4);

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_start = 1'b0;
    logic [7:0]  i_pixel = 8'h00;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [39:0] o_col;
    logic        o_col_valid;
    logic        o_center_real;
    logic        o_busy;
    logic        o_frame_done;

    smooth_col_sched #(
        .WIDTH  (W),
        .HEIGHT (H)
    ) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_start       (i_start),
        .i_pixel       (i_pixel),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .o_col         (o_col),
        .o_col_valid   (o_col_valid),
        .o_center_real (o_center_real),
        .o_busy        (o_busy),
        .o_frame_done  (o_frame_done)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [39:0] col;
        logic        ctr;
    } exp_t;

    typedef struct {
        int max_gap;
        int abort_row;
        int exp_cols;
        int exp_done;
    } case_t;

    exp_t        sb[$];
    exp_t        mon_e;
    case_t       cases[4];
    int          checks = 0;
    int          errors = 0;
    int          col_cnt = 0;
    int          done_cnt = 0;
    logic [39:0] obs[COLS];
    bit          stall_pend = 1'b0;
    bit          rep_mode = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] pix(input int y, input int x);
        return 8'(16 * y + x);
    endfunction

    // Reference: centre row c, column k of W+4; rows outside the frame are zero.
    task automatic push_frame();
        for (int c = 0; c < H; c++) begin
            for (int k = 0; k < W + 4; k++) begin
                exp_t e;
                int   x;
                x     = k - 2;
                e.col = '0;
                e.ctr = (k >= 4);
                if (x >= 0 && x < W) begin
                    for (int r = 0; r < 5; r++) begin
                        int yy;
                        yy = c - 2 + r;
                        if (yy >= 0 && yy < H) e.col[8*(4-r) +: 8] = pix(yy, x);
                    end
                end
                sb.push_back(e);
            end
        end
    endtask

    always @(negedge i_clk) begin
        if (stall_pend) chk("stall_no_col", {63'd0, o_col_valid}, 64'd0);
        stall_pend = o_ready && !i_valid && !i_rst;
        if (o_col_valid) begin
            if (col_cnt < COLS) obs[col_cnt] = o_col;
            col_cnt++;
            if (rep_mode) begin
                chk("rep_col", {24'd0, o_col}, 64'h80_8080_8080);
            end else if (sb.size() == 0) begin
                chk("sb_extra_col", 64'(sb.size()), 64'd1);
            end else begin
                mon_e = sb.pop_front();
                chk("col", {24'd0, o_col}, {24'd0, mon_e.col});
                chk("center_real", {63'd0, o_center_real}, {63'd0, mon_e.ctr});
            end
        end
        if (o_frame_done) begin
            done_cnt++;
            chk("busy_at_done", {63'd0, o_busy}, 64'd0);
        end
    end

    task automatic send_pixel(input logic [7:0] p, input int gap, input bit st, output bit ok);
        int guard;
        guard   = 0;
        i_valid = 1'b0;
        repeat (gap) begin
            @(posedge i_clk); #1;
        end
        i_pixel = p;
        i_valid = 1'b1;
        i_start = st;
        while (!o_ready && guard < 200) begin
            @(posedge i_clk); #1;
            guard++;
        end
        ok = o_ready;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        i_start = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ready"}, {63'd0, o_ready}, 64'd0);
        chk({tag, "_col"}, {24'd0, o_col}, 64'd0);
        chk({tag, "_col_valid"}, {63'd0, o_col_valid}, 64'd0);
        chk({tag, "_center_real"}, {63'd0, o_center_real}, 64'd0);
        chk({tag, "_busy"}, {63'd0, o_busy}, 64'd0);
        chk({tag, "_frame_done"}, {63'd0, o_frame_done}, 64'd0);
    endtask

    task automatic run_frame(input int max_gap, input int abort_row);
        bit ok;
        int guard;
        col_cnt  = 0;
        done_cnt = 0;
        sb.delete();
        if (!rep_mode) push_frame();
        @(posedge i_clk); #1;
        i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                if (y == abort_row && x == 4) begin
                    i_rst = 1'b1;
                    @(negedge i_clk);
                    check_all_zero("abort");
                    @(posedge i_clk); #1;
                    i_rst = 1'b0;
                    sb.delete();
                    repeat (40) @(posedge i_clk);
                    #1;
                    return;
                end
                send_pixel(rep_mode ? 8'h80 : pix(y, x),
                           (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0,
                           (y == 0 && x == 1) || (y == 3 && x == 0), ok);
                if (!ok) begin
                    chk("accept_timeout", {63'd0, ok}, 64'd1);
                    return;
                end
            end
        end
        guard = 0;
        while (done_cnt == 0 && guard < 1000) begin
            @(posedge i_clk); #1;
            guard++;
        end
        repeat (20) @(posedge i_clk);
        #1;
        chk("sb_empty", 64'(sb.size()), 64'd0);
        chk("idle_busy", {63'd0, o_busy}, 64'd0);
    endtask

    initial begin
        cases[0] = '{max_gap: 0, abort_row: -1, exp_cols: COLS, exp_done: 1};
        cases[1] = '{max_gap: 3, abort_row: -1, exp_cols: COLS, exp_done: 1};
        cases[2] = '{max_gap: 0, abort_row: 3,  exp_cols: 17,   exp_done: 0};
        cases[3] = '{max_gap: 0, abort_row: -1, exp_cols: COLS, exp_done: 1};

        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        check_all_zero("reset");
        @(posedge i_clk); #1;
        i_rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            run_frame(cases[i].max_gap, cases[i].abort_row);
            chk($sformatf("case%0d_cols", i), 64'(col_cnt), 64'(cases[i].exp_cols));
            chk($sformatf("case%0d_done", i), 64'(done_cnt), 64'(cases[i].exp_done));
            if (i == 0) begin
                chk("row2_x3_col", {24'd0, obs[29]}, 64'h03_1323_3343);
                for (int x = 0; x < W; x++) begin
                    chk($sformatf("drain0_x%0d_bottom", x), {56'd0, obs[50+x][7:0]}, 64'd0);
                    chk($sformatf("drain0_x%0d_top", x), {56'd0, obs[50+x][39:32]}, 64'(8'h20 + x));
                    chk($sformatf("drain1_x%0d_bottom", x), {48'd0, obs[62+x][15:0]}, 64'd0);
                    chk($sformatf("drain1_x%0d_top", x), {56'd0, obs[62+x][39:32]}, 64'(8'h30 + x));
                end
            end
        end

`ifdef SMOOTH_REPLICATE_EN
        rep_mode = 1'b1;
        run_frame(0, -1);
        chk("rep_cols", 64'(col_cnt), 64'(COLS));
        chk("rep_done", 64'(done_cnt), 64'd1);
        rep_mode = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected frame completion");
        $fatal(1);
    end

endmodule

`default_nettype wire
